// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;

    localparam int FRAME_BITS = 11;
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = OVERSAMPLE / 2 - 1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an idle-high asynchronous line; clears to 1.
module uart_sync2 (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic meta;

    // Metastability flop followed by the output flop, both preset high.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, start-glitch rejection, even parity and
// stop check, single-byte holding register with ready/overrun flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk16x,
    input  logic                 clr,
    input  logic                 rxd,
    input  logic                 rdn,
    output logic [DATA_BITS-1:0] d_out,
    output logic                 r_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 receiving
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic                 rxd_s;
    rx_state_t            state, state_next;
    logic [CW-1:0]        cnt, cnt_next;
    logic [BW-1:0]        bitn, bitn_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 p_err, p_err_next;
    logic                 commit;

    uart_sync2 u_sync (
        .clk (clk16x),
        .clr (clr),
        .d   (rxd),
        .q   (rxd_s)
    );

    // Frame state and datapath registers.
    always_ff @(posedge clk16x or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            cnt   <= '0;
            bitn  <= '0;
            shift <= '0;
            p_err <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            bitn  <= bitn_next;
            shift <= shift_next;
            p_err <= p_err_next;
        end
    end

    // Next-state, sub-bit counter and bit capture.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bitn_next  = bitn;
        shift_next = shift;
        p_err_next = p_err;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rxd_s) begin
                    state_next = START;
                end else begin
                    state_next = IDLE;
                end
            end
            START: begin
                if (cnt == CNT_MID) begin
                    cnt_next = '0;
                    // A start bit that is high again at its midpoint is a glitch.
                    if (!rxd_s) begin
                        state_next = DATA;
                        bitn_next  = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_next         = '0;
                    shift_next[bitn] = rxd_s;
                    bitn_next        = bitn + 1'b1;
                    if (bitn == BIT_LAST) begin
                        state_next = PARITY;
                    end else begin
                        state_next = DATA;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    p_err_next = rxd_s ^ (^shift);
                    state_next = STOP;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    commit   = 1'b1;
                    // A low stop bit means break or stuck line: wait for idle first.
                    if (rxd_s) begin
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT_HIGH;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            WAIT_HIGH: begin
                cnt_next = '0;
                if (rxd_s) begin
                    state_next = IDLE;
                end else begin
                    state_next = WAIT_HIGH;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // CPU-visible holding register, flags and activity indicator.
    always_ff @(posedge clk16x or posedge clr) begin
        if (clr) begin
            d_out      <= '0;
            r_ready    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            receiving  <= 1'b0;
        end else begin
            receiving <= (state_next == START) || (state_next == DATA) ||
                         (state_next == PARITY) || (state_next == STOP);
            if (commit) begin
                d_out      <= shift;
                r_ready    <= 1'b1;
                parity_err <= p_err;
                frame_err  <= ~rxd_s;
                overrun    <= r_ready & rdn;
            end else if (!rdn) begin
                r_ready <= 1'b0;
            end else begin
                r_ready <= r_ready;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, random frames against a
// frame-level reference model, and hand-built corner-case sequences.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int LATENCY = 2 + 8 + 16 * 9 + 16;

    logic       clk16x = 1'b0;
    logic       clr;
    logic       rxd;
    logic       rdn;
    logic [7:0] d_out;
    logic       r_ready, parity_err, frame_err, overrun, receiving;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int fall_cyc    = 0;
    int rise_cyc    = 0;
    int rise_count  = 0;
    logic ready_prev = 1'b0;
    logic m_pending;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk16x     (clk16x),
        .clr        (clr),
        .rxd        (rxd),
        .rdn        (rdn),
        .d_out      (d_out),
        .r_ready    (r_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .receiving  (receiving)
    );

    always #5 clk16x = ~clk16x;

    always @(posedge clk16x) cyc <= cyc + 1;

    always @(negedge clk16x) begin
        if (r_ready && !ready_prev) begin
            rise_cyc = cyc;
            rise_count++;
        end
        ready_prev = r_ready;
    end

    typedef struct {
        logic [7:0] data;
        logic       par_flip;
        logic       stop_bit;
        logic       read_first;
        logic       exp_pe;
        logic       exp_fe;
        logic       exp_ov;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk16x);
    endtask

    task automatic read_pulse();
        @(negedge clk16x);
        rdn = 1'b0;
        @(negedge clk16x);
        rdn = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par_flip,
                              input logic stop_bit, input logic rd_at_commit,
                              input logic hold_low);
        logic [10:0] fb;
        fb = {stop_bit, (^data) ^ par_flip, data, 1'b0};
        rise_cyc = 0;
        for (int i = 0; i < FRAME_BITS * OVERSAMPLE; i++) begin
            @(negedge clk16x);
            rxd = fb[i / OVERSAMPLE];
            if (i == 0) fall_cyc = cyc;
            rdn = (rd_at_commit && i == LATENCY) ? 1'b0 : 1'b1;
        end
        @(negedge clk16x);
        rxd = hold_low ? 1'b0 : 1'b1;
        rdn = 1'b1;
        wait_cycles(24);
    endtask

    task automatic check_latency(input string name);
        int lat;
        lat = rise_cyc - fall_cyc - 1;
        check(name, (lat >= LATENCY - 1 && lat <= LATENCY + 1) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        clr = 1'b1;
        rxd = 1'b1;
        rdn = 1'b1;
        wait_cycles(3);
        check("reset_outputs", {d_out, r_ready, parity_err, frame_err, overrun, receiving}, 32'd0);
        @(negedge clk16x);
        clr = 1'b0;
        wait_cycles(4);

        tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        for (int k = 0; k < 7; k++) begin
            if (tbl[k].read_first) read_pulse();
            send_frame(tbl[k].data, tbl[k].par_flip, tbl[k].stop_bit, 1'b0, 1'b0);
            check("tbl_d_out", d_out, tbl[k].data);
            check("tbl_r_ready", r_ready, 1'b1);
            check("tbl_parity_err", parity_err, tbl[k].exp_pe);
            check("tbl_frame_err", frame_err, tbl[k].exp_fe);
            check("tbl_overrun", overrun, tbl[k].exp_ov);
            check("tbl_receiving", receiving, 1'b0);
            if (tbl[k].read_first) check_latency("tbl_latency");
        end

        // Reading clears ready but leaves data and flags alone.
        read_pulse();
        check("rd_r_ready", r_ready, 1'b0);
        check("rd_overrun_held", overrun, 1'b1);
        check("rd_parity_held", parity_err, 1'b1);
        check("rd_d_out_held", d_out, 8'h80);
        send_frame(8'h44, 1'b0, 1'b1, 1'b0, 1'b0);
        check("ov_clear_overrun", overrun, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
        check("rd_commit_d_out", d_out, 8'h55);
        check("rd_commit_r_ready", r_ready, 1'b1);
        check("rd_commit_overrun", overrun, 1'b0);

        // Start glitch: flags and pending byte must survive untouched.
        send_frame(8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
        begin
            int rc0, rcv;
            rc0 = rise_count;
            rcv = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk16x);
                rxd = (i < 4) ? 1'b0 : 1'b1;
                if (receiving) rcv++;
            end
            check("glitch_rcv_pulse", (rcv >= 1 && rcv <= MID_SAMPLE + 2) ? 32'd1 : 32'd0, 32'd1);
            check("glitch_no_commit", rise_count - rc0, 32'd0);
            check("glitch_r_ready", r_ready, 1'b1);
            check("glitch_d_out", d_out, 8'h03);
            check("glitch_parity", parity_err, 1'b1);
            check("glitch_overrun", overrun, 1'b1);
        end

        // Break: stuck-low line after a bad stop bit commits exactly once.
        read_pulse();
        begin
            int rc0;
            rc0 = rise_count;
            send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
            check("brk_d_out", d_out, 8'h00);
            check("brk_frame_err", frame_err, 1'b1);
            wait_cycles(200);
            read_pulse();
            wait_cycles(200);
            check("brk_one_commit", rise_count - rc0, 32'd1);
            check("brk_r_ready_low", r_ready, 1'b0);
            @(negedge clk16x);
            rxd = 1'b1;
            wait_cycles(40);
            check("brk_idle_no_commit", rise_count - rc0, 32'd1);
            send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
            check("brk_after_commit", rise_count - rc0, 32'd2);
            check("brk_after_d_out", d_out, 8'h3C);
            check("brk_after_frame_err", frame_err, 1'b0);
        end

        // Reset in the middle of data bit 4.
        begin
            logic [10:0] fb;
            fb = {1'b1, ^8'hC3, 8'hC3, 1'b0};
            for (int i = 0; i < 5 * OVERSAMPLE + 8; i++) begin
                @(negedge clk16x);
                rxd = fb[i / OVERSAMPLE];
            end
            @(negedge clk16x);
            clr = 1'b1;
            #1;
            check("midrst_outputs", {d_out, r_ready, parity_err, frame_err, overrun, receiving}, 32'd0);
            @(negedge clk16x);
            clr = 1'b0;
            rxd = 1'b1;
            wait_cycles(200);
            check("midrst_no_commit", r_ready, 1'b0);
            send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
            check("midrst_d_out", d_out, 8'h5A);
            check("midrst_r_ready", r_ready, 1'b1);
            check("midrst_flags", {parity_err, frame_err, overrun}, 3'b000);
            check_latency("midrst_latency");
        end

        // Random frames against the frame-level reference model.
        read_pulse();
        m_pending = 1'b0;
        for (int n = 0; n < 40; n++) begin
            logic [7:0] data;
            logic pf, sb, rf, pbit, exp_pe, exp_ov;
            data = 8'($urandom);
            pf   = ($urandom_range(0, 5) == 0);
            sb   = ($urandom_range(0, 5) != 0);
            rf   = 1'($urandom_range(0, 1));
            if (rf) begin
                read_pulse();
                m_pending = 1'b0;
            end
            pbit   = 1'(($countones(data) + (pf ? 1 : 0)) % 2);
            exp_pe = (($countones(data) + pbit) % 2) != 0;
            exp_ov = m_pending;
            send_frame(data, pf, sb, 1'b0, 1'b0);
            m_pending = 1'b1;
            check("rnd_d_out", d_out, data);
            check("rnd_r_ready", r_ready, 1'b1);
            check("rnd_parity_err", parity_err, exp_pe);
            check("rnd_frame_err", frame_err, !sb);
            check("rnd_overrun", overrun, exp_ov);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
